// File: rtl/wm_extractor.sv
// Watermark extractor: recovers ll2 = (llw - ll1) / alpha with a restoring divider.
// Latency: 2N+1 cycles from accept to out_valid (1 cycle on the error paths).
// Backpressure: one transaction in flight; in_ready low until the result is taken.
module wm_extractor #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] llw,
  input  logic [N-1:0]   ll1,
  input  logic [N-1:0]   alpha,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   ll2,
  output logic [N-1:0]   rem,
  output logic           err_div0,
  output logic           err_under,
  output logic           sat
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] CNT_INIT = CW'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   llw_q, llw_d;
  logic [N-1:0]     ll1_q, ll1_d;
  logic [N-1:0]     alpha_q, alpha_d;
  logic [2*N-1:0]   dvd_q, dvd_d;
  logic [N:0]       r_q, r_d;
  logic [2*N-1:0]   quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     ll2_q, ll2_d;
  logic [N-1:0]     rem_q, rem_d;
  logic             err_div0_q, err_div0_d;
  logic             err_under_q, err_under_d;
  logic             sat_q, sat_d;

  // One restoring step: shift in the dividend MSB, subtract alpha when it fits.
  logic [2*N-1:0]   diff;
  logic [N:0]       r_shift;
  logic [N:0]       r_new;
  logic             q_bit;
  logic [2*N-1:0]   quo_new;

  // Datapath for the current divider step, evaluated every cycle.
  always_comb begin
    diff    = llw_q - {{N{1'b0}}, ll1_q};
    r_shift = {r_q[N-1:0], dvd_q[2*N-1]};
    q_bit   = (r_shift >= {1'b0, alpha_q});
    r_new   = q_bit ? (r_shift - {1'b0, alpha_q}) : r_shift;
    quo_new = {quo_q[2*N-2:0], q_bit};
  end

  // Next-state and register updates for the IDLE/SUB/DIV/DONE sequence.
  always_comb begin
    state_d     = state_q;
    llw_d       = llw_q;
    ll1_d       = ll1_q;
    alpha_d     = alpha_q;
    dvd_d       = dvd_q;
    r_d         = r_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    ll2_d       = ll2_q;
    rem_d       = rem_q;
    err_div0_d  = err_div0_q;
    err_under_d = err_under_q;
    sat_d       = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          llw_d   = llw;
          ll1_d   = ll1;
          alpha_d = alpha;
          state_d = SUB;
        end
      end
      SUB: begin
        if (alpha_q == '0) begin
          // Divide-by-zero wins over underflow so only one flag is ever set.
          ll2_d       = '0;
          rem_d       = '0;
          err_div0_d  = 1'b1;
          err_under_d = 1'b0;
          sat_d       = 1'b0;
          state_d     = DONE;
        end else if (llw_q < {{N{1'b0}}, ll1_q}) begin
          ll2_d       = '0;
          rem_d       = '0;
          err_div0_d  = 1'b0;
          err_under_d = 1'b1;
          sat_d       = 1'b0;
          state_d     = DONE;
        end else begin
          dvd_d   = diff;
          r_d     = '0;
          quo_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = DIV;
        end
      end
      DIV: begin
        dvd_d = {dvd_q[2*N-2:0], 1'b0};
        r_d   = r_new;
        quo_d = quo_new;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Quotient is 2N bits wide; anything above N bits clamps to all ones.
          if (quo_new[2*N-1:N] != '0) begin
            ll2_d = '1;
            sat_d = 1'b1;
          end else begin
            ll2_d = quo_new[N-1:0];
            sat_d = 1'b0;
          end
          rem_d       = r_new[N-1:0];
          err_div0_d  = 1'b0;
          err_under_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      llw_q       <= '0;
      ll1_q       <= '0;
      alpha_q     <= '0;
      dvd_q       <= '0;
      r_q         <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      ll2_q       <= '0;
      rem_q       <= '0;
      err_div0_q  <= 1'b0;
      err_under_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      llw_q       <= llw_d;
      ll1_q       <= ll1_d;
      alpha_q     <= alpha_d;
      dvd_q       <= dvd_d;
      r_q         <= r_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      ll2_q       <= ll2_d;
      rem_q       <= rem_d;
      err_div0_q  <= err_div0_d;
      err_under_q <= err_under_d;
      sat_q       <= sat_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ll2       = ll2_q;
  assign rem       = rem_q;
  assign err_div0  = err_div0_q;
  assign err_under = err_under_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_wm_extractor.sv
module tb_wm_extractor;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] llw = '0;
  logic [N-1:0]   ll1 = '0;
  logic [N-1:0]   alpha = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   ll2;
  logic [N-1:0]   rem;
  logic           err_div0;
  logic           err_under;
  logic           sat;

  int pass_cnt = 0;
  int total_cnt = 0;

  wm_extractor #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .llw(llw), .ll1(ll1), .alpha(alpha),
    .out_valid(out_valid), .out_ready(out_ready),
    .ll2(ll2), .rem(rem),
    .err_div0(err_div0), .err_under(err_under), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] llw;
    logic [N-1:0]   ll1;
    logic [N-1:0]   alpha;
    logic [N-1:0]   ll2;
    logic [N-1:0]   rem;
    logic           div0;
    logic           under;
    logic           sat;
    int             lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Run one transaction from IDLE, holding out_ready low for 'hold' cycles once valid.
  task automatic do_txn(input vec_t v, input int hold, input string tag);
    int lat;
    chk({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    llw = v.llw; ll1 = v.ll1; alpha = v.alpha; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    llw = 32'hDEAD_BEEF; ll1 = 16'h1234; alpha = 16'h0000;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " ll2"}, 32'(ll2), 32'(v.ll2));
    chk({tag, " rem"}, 32'(rem), 32'(v.rem));
    chk({tag, " err_div0"}, 32'(err_div0), 32'(v.div0));
    chk({tag, " err_under"}, 32'(err_under), 32'(v.under));
    chk({tag, " sat"}, 32'(sat), 32'(v.sat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold ll2"}, 32'(ll2), 32'(v.ll2));
      chk({tag, " hold rem"}, 32'(rem), 32'(v.rem));
    end
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready during out_ready"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
    chk({tag, " ll2 kept after take"}, 32'(ll2), 32'(v.ll2));
  endtask

  initial begin
    vec_t vecs[9];
    vec_t v;
    logic [N-1:0] r_ll1, r_ll2, r_alpha;

    //          llw            ll1     alpha     ll2       rem   div0  under sat   lat
    vecs[0] = '{32'd47,        16'd5,  16'd6,    16'd7,    16'd0, 1'b0, 1'b0, 1'b0, 33};
    vecs[1] = '{32'd100,       16'd5,  16'd0,    16'd0,    16'd0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2] = '{32'd3,         16'd5,  16'd0,    16'd0,    16'd0, 1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{32'd3,         16'd5,  16'd2,    16'd0,    16'd0, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{32'd5,         16'd5,  16'd7,    16'd0,    16'd0, 1'b0, 1'b0, 1'b0, 33};
    vecs[5] = '{32'hFFFE_0001, 16'd0,  16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 1'b0, 33};
    vecs[6] = '{32'hFFFF_FFFF, 16'd0,  16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 1'b1, 33};
    vecs[7] = '{32'h0001_0000, 16'd0,  16'd1,    16'hFFFF, 16'd0, 1'b0, 1'b0, 1'b1, 33};
    vecs[8] = '{32'd20,        16'd2,  16'd3,    16'd6,    16'd0, 1'b0, 1'b0, 1'b0, 33};

    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset ll2", 32'(ll2), 32'd0);
    chk("reset rem", 32'(rem), 32'd0);
    chk("reset flags", {29'd0, err_div0, err_under, sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) do_txn(vecs[i], 0, $sformatf("vec%0d", i));

    // Remainder with back-pressure: 45/6 = 7 r 3, held for 10 cycles.
    v = '{32'd50, 16'd5, 16'd6, 16'd7, 16'd3, 1'b0, 1'b0, 1'b0, 33};
    do_txn(v, 10, "bp");

    // Abort mid-divide: last result (ll2=7, rem=3) must be wiped by reset.
    @(negedge clk);
    llw = 32'd47; ll1 = 16'd5; alpha = 16'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst ll2", 32'(ll2), 32'd0);
    chk("midrst rem", 32'(rem), 32'd0);
    chk("midrst flags", {29'd0, err_div0, err_under, sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_txn(vecs[0], 0, "after_rst");

    // Embed -> extract round trips with small coefficients.
    for (int i = 0; i < 20; i++) begin
      r_ll1   = 16'($urandom_range(0, 9));
      r_ll2   = 16'($urandom_range(0, 9));
      r_alpha = 16'($urandom_range(1, 9));
      v.llw   = 32'(r_ll1) + 32'(r_alpha) * 32'(r_ll2);
      v.ll1   = r_ll1;
      v.alpha = r_alpha;
      v.ll2   = r_ll2;
      v.rem   = 16'd0;
      v.div0  = 1'b0;
      v.under = 1'b0;
      v.sat   = 1'b0;
      v.lat   = 33;
      do_txn(v, 0, $sformatf("rt%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
